// File: rtl/ctrl_pkg.sv
// Shared definitions for the sequenced control unit: opcode and ALU encodings,
// FSM state type and the registered control word.
package ctrl_pkg;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SLL     = 3'b001;
  localparam logic [2:0] OP_NOP     = 3'b010;
  localparam logic [2:0] OP_JUMP    = 3'b011;
  localparam logic [2:0] OP_SUB     = 3'b100;
  localparam logic [2:0] OP_SRL     = 3'b101;
  localparam logic [2:0] OP_BEQ     = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SLL = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_SRL = 2'b11;

  // Flush countdown width; holds FLUSH_CYCLES in 0..15.
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    BR_RESOLVE = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  typedef struct packed {
    logic       pc_source;
    logic [1:0] alu_ctrl;
    logic       alu_source;
    logic       reg_write;
  } ctrl_word_t;

  function automatic ctrl_word_t make_ctrl(input logic       pc,
                                           input logic [1:0] alu,
                                           input logic       src,
                                           input logic       wr);
    ctrl_word_t c;
    c.pc_source  = pc;
    c.alu_ctrl   = alu;
    c.alu_source = src;
    c.reg_write  = wr;
    return c;
  endfunction

  localparam ctrl_word_t CTRL_NOP   = '0;
  // Taken branch: redirect the PC, nothing else active.
  localparam ctrl_word_t CTRL_TAKEN = make_ctrl(1'b1, ALU_ADD, 1'b0, 1'b0);

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: produces the datapath control word plus
// classification flags used by the sequencing FSM.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int LEGACY = 0
) (
  input  logic [2:0] opcode,
  output ctrl_word_t ctrl,
  output logic       is_jump,
  output logic       is_beq,
  output logic       is_illegal
);

  logic       legacy_mode;
  logic [2:0] op_eff;

  // Legacy parts only have the 2-bit opcode space, so bit 2 is masked off.
  assign legacy_mode = (LEGACY != 0);
  assign op_eff      = {opcode[2] & ~legacy_mode, opcode[1:0]};

  // Opcode to control word lookup; unlisted encodings fall through to NOP.
  always_comb begin
    ctrl       = CTRL_NOP;
    is_jump    = 1'b0;
    is_beq     = 1'b0;
    is_illegal = 1'b0;
    case (op_eff)
      OP_ADD:  ctrl = make_ctrl(1'b0, ALU_ADD, 1'b0, 1'b1);
      OP_SLL:  ctrl = make_ctrl(1'b0, ALU_SLL, 1'b1, 1'b1);
      OP_SUB:  ctrl = make_ctrl(1'b0, ALU_SUB, 1'b0, 1'b1);
      OP_SRL:  ctrl = make_ctrl(1'b0, ALU_SRL, 1'b1, 1'b1);
      OP_NOP:  ctrl = CTRL_NOP;
      OP_JUMP: begin
        ctrl    = make_ctrl(1'b1, ALU_ADD, 1'b1, 1'b0);
        is_jump = 1'b1;
      end
      OP_BEQ: begin
        ctrl   = make_ctrl(1'b0, ALU_SUB, 1'b0, 1'b0);
        is_beq = 1'b1;
      end
      OP_ILLEGAL: is_illegal = 1'b1;
      default:    ctrl = CTRL_NOP;
    endcase
  end

endmodule

// File: rtl/seq_control_unit.sv
// Registered control unit between fetch and the ALU/regfile/PC mux.
// Accepts opcodes over a valid/ready handshake, presents decoded controls one
// cycle later, resolves BEQ from alu_zero and inserts flush bubbles after
// taken control transfers.
module seq_control_unit
  import ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter int LEGACY       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [2:0]       opcode,
  output logic             instr_ready,
  input  logic             stall,
  input  logic             alu_zero,
  output logic             pc_source,
  output logic [1:0]       alu_ctrl,
  output logic             alu_source,
  output logic             reg_write,
  output logic             flush,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  state_t                 state;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
  ctrl_word_t             ctrl_p1;
  logic                   flush_p1;
  logic                   illegal_p1;

  ctrl_word_t dec_ctrl;
  logic       dec_jump;
  logic       dec_beq;
  logic       dec_illegal;
  logic       accept;

  // Stall only matters while fetching; resolution and flush run regardless.
  assign instr_ready = (state == RUN) && !stall;
  assign accept      = instr_valid && instr_ready;

  ctrl_decode #(
    .LEGACY(LEGACY)
  ) u_decode (
    .opcode    (opcode),
    .ctrl      (dec_ctrl),
    .is_jump   (dec_jump),
    .is_beq    (dec_beq),
    .is_illegal(dec_illegal)
  );

  // Sequencing FSM with registered control outputs and flush countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_cnt  <= '0;
      ctrl_p1    <= CTRL_NOP;
      flush_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
    end else begin
      ctrl_p1    <= CTRL_NOP;
      flush_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            ctrl_p1    <= dec_ctrl;
            flush_p1   <= dec_jump;
            illegal_p1 <= dec_illegal;
            if (dec_jump && (FLUSH_LOAD != '0)) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end else if (dec_beq) begin
              state <= BR_RESOLVE;
            end
          end
        end
        BR_RESOLVE: begin
          // BEQ controls are on the outputs this cycle; alu_zero decides at its end.
          if (alu_zero) begin
            ctrl_p1  <= CTRL_TAKEN;
            flush_p1 <= 1'b1;
            if (FLUSH_LOAD != '0) begin
              state     <= FLUSH;
              flush_cnt <= FLUSH_LOAD;
            end else begin
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        FLUSH: begin
          // Each remaining count adds one more contiguous flush-high cycle.
          if (flush_cnt == '0) begin
            state <= RUN;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
            flush_p1  <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Retired-instruction counter: accepted legal opcodes, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_count <= '0;
    end else if (accept && !dec_illegal) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

  assign pc_source  = ctrl_p1.pc_source;
  assign alu_ctrl   = ctrl_p1.alu_ctrl;
  assign alu_source = ctrl_p1.alu_source;
  assign reg_write  = ctrl_p1.reg_write;
  assign flush      = flush_p1;
  assign illegal    = illegal_p1;

endmodule

// File: tb/tb_seq_control_unit.sv
// Directed bench for seq_control_unit. Instance A: FLUSH_CYCLES=2, CNT_W=16.
// Instance B: LEGACY=1, CNT_W=4, FLUSH_CYCLES=1. Inputs are shared; each
// instance has its own reset so one is parked in reset while the other runs.
module tb_seq_control_unit;

  localparam logic [2:0] O_ADD = 3'b000, O_SLL = 3'b001, O_JUMP = 3'b011,
                         O_SUB = 3'b100, O_SRL = 3'b101, O_BEQ = 3'b110,
                         O_ILL = 3'b111;

  // Output vector layout: {pc_source, alu_ctrl[1:0], alu_source, reg_write, flush, illegal}
  localparam logic [6:0] E_NOP = 7'b0_00_0_0_0_0;
  localparam logic [6:0] E_ADD = 7'b0_00_0_1_0_0;
  localparam logic [6:0] E_SLL = 7'b0_01_1_1_0_0;
  localparam logic [6:0] E_SUB = 7'b0_10_0_1_0_0;
  localparam logic [6:0] E_SRL = 7'b0_11_1_1_0_0;
  localparam logic [6:0] E_JMP = 7'b1_00_1_0_1_0;
  localparam logic [6:0] E_BEQ = 7'b0_10_0_0_0_0;
  localparam logic [6:0] E_TKN = 7'b1_00_0_0_1_0;
  localparam logic [6:0] E_FL  = 7'b0_00_0_0_1_0;
  localparam logic [6:0] E_ILL = 7'b0_00_0_0_0_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a_n, rst_b_n;
  logic       instr_valid, stall, alu_zero;
  logic [2:0] opcode;

  logic        rdy_a, pc_a, src_a, wr_a, fl_a, ill_a;
  logic [1:0]  ctrl_a;
  logic [15:0] cnt_a;
  logic        rdy_b, pc_b, src_b, wr_b, fl_b, ill_b;
  logic [1:0]  ctrl_b;
  logic [3:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  logic [6:0] exp_q[$];
  string      tag_q[$];

  seq_control_unit #(.FLUSH_CYCLES(2), .CNT_W(16), .LEGACY(0)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(rdy_a), .stall(stall), .alu_zero(alu_zero),
    .pc_source(pc_a), .alu_ctrl(ctrl_a), .alu_source(src_a), .reg_write(wr_a),
    .flush(fl_a), .illegal(ill_a), .retired_count(cnt_a)
  );

  seq_control_unit #(.FLUSH_CYCLES(1), .CNT_W(4), .LEGACY(1)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .instr_valid(instr_valid), .opcode(opcode),
    .instr_ready(rdy_b), .stall(stall), .alu_zero(alu_zero),
    .pc_source(pc_b), .alu_ctrl(ctrl_b), .alu_source(src_b), .reg_write(wr_b),
    .flush(fl_b), .illegal(ill_b), .retired_count(cnt_b)
  );

  function automatic logic [6:0] obs(input bit sel);
    if (sel) return {pc_b, ctrl_b, src_b, wr_b, fl_b, ill_b};
    return {pc_a, ctrl_a, src_a, wr_a, fl_a, ill_a};
  endfunction

  task automatic check7(input string tag, input logic [6:0] o, input logic [6:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic check1(input string tag, input logic o, input logic e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  task automatic check_cnt(input string tag, input bit sel, input logic [15:0] e);
    logic [15:0] o;
    o = sel ? {12'b0, cnt_b} : cnt_a;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // One clock: drive inputs, check ready, push the expected registered outputs,
  // then pop and compare them one edge later. Called at posedge + 1.
  task automatic cycle(input bit sel, input logic v, input logic [2:0] op,
                       input logic st, input logic az, input logic rdy,
                       input logic [6:0] e, input string tag);
    logic [6:0] ex;
    string      tg;
    instr_valid = v;
    opcode      = op;
    stall       = st;
    alu_zero    = az;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check1({tag, ".rdy"}, sel ? rdy_b : rdy_a, rdy);
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    tg = tag_q.pop_front();
    check7(tg, obs(sel), ex);
  endtask

  initial begin
    rst_a_n     = 1'b0;
    rst_b_n     = 1'b0;
    instr_valid = 1'b0;
    opcode      = 3'b000;
    stall       = 1'b0;
    alu_zero    = 1'b0;
    @(posedge clk);
    #1;
    check7("reset_outs_a", obs(1'b0), E_NOP);
    check1("reset_rdy_a", rdy_a, 1'b1);
    check_cnt("reset_cnt_a", 1'b0, 16'd0);
    @(posedge clk);
    #1;
    rst_a_n = 1'b1;
    @(posedge clk);
    #1;

    // 1. ALU ops back-to-back
    cycle(0, 1, O_ADD, 0, 0, 1, E_ADD, "add");
    cycle(0, 1, O_SLL, 0, 0, 1, E_SLL, "sll");
    cycle(0, 1, O_SUB, 0, 0, 1, E_SUB, "sub");
    cycle(0, 1, O_SRL, 0, 0, 1, E_SRL, "srl");
    check_cnt("cnt_after_alu", 1'b0, 16'd4);
    cycle(0, 0, O_ADD, 0, 0, 1, E_NOP, "idle_nop");

    // 2. JUMP with two extra flush cycles, fetch held off throughout
    cycle(0, 1, O_JUMP, 0, 0, 1, E_JMP, "jump");
    cycle(0, 1, O_ADD, 0, 0, 0, E_FL, "jump_fl1");
    cycle(0, 1, O_ADD, 0, 0, 0, E_FL, "jump_fl2");
    cycle(0, 1, O_ADD, 0, 0, 0, E_NOP, "jump_end");
    cycle(0, 1, O_ADD, 0, 0, 1, E_ADD, "jump_next_add");
    check_cnt("cnt_after_jump", 1'b0, 16'd6);

    // 4b. stall during FLUSH does not stretch it
    cycle(0, 1, O_JUMP, 0, 0, 1, E_JMP, "jump_st");
    cycle(0, 1, O_ADD, 1, 0, 0, E_FL, "jump_st_fl1");
    cycle(0, 1, O_ADD, 1, 0, 0, E_FL, "jump_st_fl2");
    cycle(0, 1, O_ADD, 1, 0, 0, E_NOP, "jump_st_end");
    cycle(0, 1, O_ADD, 0, 0, 1, E_ADD, "jump_st_add");
    check_cnt("cnt_after_jump_st", 1'b0, 16'd8);

    // 3. BEQ taken
    cycle(0, 1, O_BEQ, 0, 0, 1, E_BEQ, "beq_t");
    cycle(0, 1, O_ADD, 0, 1, 0, E_TKN, "beq_t_resolve");
    cycle(0, 1, O_ADD, 0, 0, 0, E_FL, "beq_t_fl1");
    cycle(0, 1, O_ADD, 0, 0, 0, E_FL, "beq_t_fl2");
    cycle(0, 1, O_ADD, 0, 0, 0, E_NOP, "beq_t_end");
    cycle(0, 1, O_ADD, 0, 0, 1, E_ADD, "beq_t_add");

    // 3b. BEQ not taken
    cycle(0, 1, O_BEQ, 0, 1, 1, E_BEQ, "beq_n");
    cycle(0, 1, O_ADD, 0, 0, 0, E_NOP, "beq_n_resolve");
    cycle(0, 1, O_ADD, 0, 0, 1, E_ADD, "beq_n_add");
    check_cnt("cnt_after_beq", 1'b0, 16'd12);

    // 4. stall in RUN blocks acceptance
    for (int i = 0; i < 3; i++) cycle(0, 1, O_ADD, 1, 0, 0, E_NOP, "stall_run");
    cycle(0, 1, O_ADD, 0, 0, 1, E_ADD, "stall_release_add");
    check_cnt("cnt_after_stall", 1'b0, 16'd13);

    // 5. illegal opcode pulses once, not counted; X opcode while invalid ignored
    cycle(0, 1, O_ILL, 0, 0, 1, E_ILL, "illegal");
    cycle(0, 0, 3'bxxx, 0, 0, 1, E_NOP, "illegal_gone");
    check_cnt("cnt_after_illegal", 1'b0, 16'd13);

    // 6. async reset mid-FLUSH
    cycle(0, 1, O_JUMP, 0, 0, 1, E_JMP, "rst_jump");
    instr_valid = 1'b0;
    #2;
    rst_a_n = 1'b0;
    #1;
    check7("rst_mid_flush_outs", obs(1'b0), E_NOP);
    check1("rst_mid_flush_rdy", rdy_a, 1'b1);
    check_cnt("rst_mid_flush_cnt", 1'b0, 16'd0);
    #1;
    rst_a_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(0, 1, O_ADD, 0, 0, 1, E_ADD, "rst_flush_add");
    check_cnt("cnt_after_rst_add", 1'b0, 16'd1);

    // 6b. async reset mid-BR_RESOLVE abandons the branch
    cycle(0, 1, O_BEQ, 0, 0, 1, E_BEQ, "rst_beq");
    instr_valid = 1'b0;
    alu_zero    = 1'b1;
    #2;
    rst_a_n = 1'b0;
    #1;
    check7("rst_mid_br_outs", obs(1'b0), E_NOP);
    check_cnt("rst_mid_br_cnt", 1'b0, 16'd0);
    #1;
    rst_a_n = 1'b1;
    @(posedge clk);
    #1;
    check7("rst_br_after", obs(1'b0), E_NOP);
    check1("rst_br_rdy", rdy_a, 1'b1);

    // Switch to instance B (LEGACY=1, CNT_W=4, FLUSH_CYCLES=1)
    rst_a_n = 1'b0;
    rst_b_n = 1'b1;
    cycle(1, 0, O_ADD, 0, 0, 1, E_NOP, "b_idle");
    cycle(1, 1, O_ILL, 0, 0, 1, E_JMP, "b_legacy_111");
    cycle(1, 0, O_ADD, 0, 0, 0, E_FL, "b_legacy_fl");
    cycle(1, 0, O_ADD, 0, 0, 0, E_NOP, "b_legacy_end");
    check_cnt("b_cnt_after_jump", 1'b1, 16'd1);
    for (int i = 0; i < 16; i++) cycle(1, 1, O_SUB, 0, 0, 1, E_ADD, "b_legacy_100");
    check_cnt("b_cnt_wrap", 1'b1, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
